// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM state encoding and frame layout constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Frame is command(8) + address(8) + data(8), sent MSB first.
    localparam int FRAME_BITS     = 24;
    // First bit index of the data byte; reads capture miso from here on.
    localparam int DATA_START_BIT = 16;
    // Command bit that selects a read transaction.
    localparam int CMD_READ_BIT   = 7;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI serial clock generator: divides clk by 2*SCK_HALF while enabled, sck idles low.
// Latency: first sck rise SCK_HALF clk cycles after en goes high; rise/fall strobes are combinational
// Backpressure: none; dropping en clears the divider and parks sck low on the next edge.
//
// Ports:
//   clk, rst  system clock, async active-high reset
//   en        run the divider (held high by the FSM for the whole shift phase)
//   sck       registered serial clock
//   rise      high in the cycle whose closing edge drives sck 0->1
//   fall      high in the cycle whose closing edge drives sck 1->0
module spi_sck_gen #(
    parameter int SCK_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    logic [CW-1:0] half_cnt;
    logic          tick;

    // Strobes announce the toggle on the same edge that performs it, so the
    // FSM can update mosi/cs in lockstep with the sck transition.
    assign tick = en && (half_cnt == CW'(SCK_HALF - 1));
    assign rise = tick && !sck;
    assign fall = tick && sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (tick) begin
            half_cnt <= '0;
            sck      <= ~sck;
        end else begin
            half_cnt <= half_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Single-transaction SPI mode-0 master: command + address, then one data byte written or read.
// Latency: cs low 48*SCK_HALF cycles after the start edge; read data lands on the edge cs rises
// Backpressure: none; en is only looked at in IDLE and ignored for the rest of a transaction.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   en              start request (level, sampled in IDLE)
//   cs, sck, mosi   registered SPI outputs (cs active low, sck idles low)
//   miso            SPI serial input from the slave
//   ext_command_in  command byte, bit 7 set selects a read
//   ext_address_in  address byte
//   ext_data_in     write data byte
//   ext_data_out    byte captured by the most recent read, held until the next read
module spi_master import spi_pkg::*; #(
    parameter int SCK_HALF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       cs,
    output logic       sck,
    input  logic [7:0] ext_command_in,
    input  logic [7:0] ext_address_in,
    input  logic [7:0] ext_data_in,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] ext_data_out
);

    state_t      state;
    logic [4:0]  bit_idx;
    // Frame minus its first bit; that bit goes straight onto mosi at start.
    logic [22:0] tx_sr;
    logic [7:0]  rx_sr;
    logic        rd;
    logic        miso_q;
    logic        sck_rise;
    logic        sck_fall;

    spi_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == SHIFT),
        .sck  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cs           <= 1'b1;
            mosi         <= 1'b0;
            bit_idx      <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            rd           <= 1'b0;
            miso_q       <= 1'b0;
            ext_data_out <= 8'h00;
        end else begin
            miso_q <= miso;
            case (state)
                IDLE: begin
                    cs   <= 1'b1;
                    mosi <= 1'b0;
                    if (en) begin
                        tx_sr   <= {ext_command_in[6:0], ext_address_in, ext_data_in};
                        rd      <= ext_command_in[CMD_READ_BIT];
                        cs      <= 1'b0;
                        mosi    <= ext_command_in[7];
                        bit_idx <= '0;
                        rx_sr   <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise && rd && (bit_idx >= 5'(DATA_START_BIT))) begin
                        rx_sr <= {rx_sr[6:0], miso_q};
                    end
                    if (sck_fall) begin
                        if (bit_idx == 5'(FRAME_BITS - 1)) begin
                            state <= DONE;
                            cs    <= 1'b1;
                            mosi  <= 1'b0;
                            if (rd) begin
                                ext_data_out <= rx_sr;
                            end
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            tx_sr   <= {tx_sr[21:0], 1'b0};
                            // Read data phase keeps mosi quiet while the slave talks.
                            mosi    <= (rd && ((bit_idx + 5'd1) >= 5'(DATA_START_BIT))) ?
                                       1'b0 : tx_sr[22];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cs    <= 1'b1;
                    mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       en3 = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       miso = 1'b0;
    logic       cs, sck, mosi;
    logic [7:0] dout;
    logic       cs3, sck3, mosi3;
    logic [7:0] dout3;

    int checks = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_master #(.SCK_HALF(1)) dut (
        .clk(clk), .rst(rst), .en(en), .cs(cs), .sck(sck),
        .ext_command_in(cmd), .ext_address_in(addr), .ext_data_in(wdata),
        .mosi(mosi), .miso(miso), .ext_data_out(dout)
    );

    spi_master #(.SCK_HALF(3)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .cs(cs3), .sck(sck3),
        .ext_command_in(cmd), .ext_address_in(addr), .ext_data_in(wdata),
        .mosi(mosi3), .miso(miso), .ext_data_out(dout3)
    );

    // Scoreboard queues: expected mosi bits and expected ext_data_out per frame.
    logic exp_mosi[$];
    logic [7:0] exp_dout[$];
    logic [7:0] dout_model = 8'h00;

    // Slave model: mode 0, next bit presented right after each sck rise.
    logic [7:0] slave_byte = 8'h00;
    int slave_idx = 0;
    always @(negedge cs) slave_idx = 0;
    always @(posedge sck) begin
        slave_idx++;
        if (slave_idx >= 16 && slave_idx <= 23) miso = slave_byte[23 - slave_idx];
    end

    // Monitor for the SCK_HALF=1 instance.
    int mon_low = 0, mon_pulses = 0, mon_gap = 0, last_gap = 0;
    int frames_started = 0, frames_done = 0;
    logic p_sck = 1'b0, p_cs = 1'b1;
    bit aborting = 1'b0;
    logic em;
    logic [7:0] ed;

    always @(negedge clk) begin
        if (rst) begin
            p_sck = 1'b0; p_cs = 1'b1; mon_low = 0; mon_pulses = 0;
        end else begin
            if (p_cs && !cs) begin
                frames_started++; last_gap = mon_gap; mon_low = 0; mon_pulses = 0;
            end
            if (!p_cs && cs) mon_gap = 0;
            if (cs) mon_gap++; else mon_low++;
            if (sck && !p_sck) begin
                mon_pulses++;
                checks++;
                if (exp_mosi.size() == 0) begin
                    bad++; $display("FAIL mosi_unexpected: got bit %b, required no sck pulse", mosi);
                end else begin
                    em = exp_mosi.pop_front();
                    if (mosi !== em) begin
                        bad++; $display("FAIL mosi_bit: got %b required %b (pulse %0d)", mosi, em, mon_pulses);
                    end
                end
            end
            if (!p_cs && cs && !aborting) begin
                frames_done++;
                checks++;
                if (mon_low !== 48) begin
                    bad++; $display("FAIL cs_window: got %0d cycles required 48", mon_low);
                end
                checks++;
                if (mon_pulses !== 24) begin
                    bad++; $display("FAIL sck_pulses: got %0d required 24", mon_pulses);
                end
                checks++;
                if (exp_dout.size() == 0) begin
                    bad++; $display("FAIL dout_unexpected: frame ended with no expectation");
                end else begin
                    ed = exp_dout.pop_front();
                    if (dout !== ed) begin
                        bad++; $display("FAIL ext_data_out: got %h required %h", dout, ed);
                    end
                end
            end
            p_sck = sck; p_cs = cs;
        end
    end

    // Monitor for the SCK_HALF=3 instance: records window, pulse count and gap.
    int low3 = 0, pulses3 = 0, gap3 = 0;
    int low3_q[$], pulses3_q[$], gap3_q[$];
    logic p_sck3 = 1'b0, p_cs3 = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            p_sck3 = 1'b0; p_cs3 = 1'b1; low3 = 0; pulses3 = 0;
        end else begin
            if (p_cs3 && !cs3) begin gap3_q.push_back(gap3); low3 = 0; pulses3 = 0; end
            if (!p_cs3 && cs3) begin low3_q.push_back(low3); pulses3_q.push_back(pulses3); gap3 = 0; end
            if (cs3) gap3++; else low3++;
            if (sck3 && !p_sck3) pulses3++;
            p_sck3 = sck3; p_cs3 = cs3;
        end
    end

    task automatic start_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                               input logic [7:0] s, input int plen);
        logic [23:0] f;
        f = {c, a, d};
        for (int i = 23; i >= 0; i--) exp_mosi.push_back((c[7] && i < 8) ? 1'b0 : f[i]);
        if (c[7]) dout_model = s;
        exp_dout.push_back(dout_model);
        cmd = c; addr = a; wdata = d; slave_byte = s;
        @(negedge clk);
        en = 1'b1;
        repeat (plen) @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (frames_done < target && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (frames_done < target) begin
            bad++; $display("FAIL %s_timeout: got %0d frames required %0d", name, frames_done, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #50;
        @(negedge clk);
        checks++; if (cs !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b required 1", cs); end
        checks++; if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b required 0", sck); end
        checks++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b required 0", mosi); end
        checks++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h required 00", dout); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int base = frames_done;
        start_frame(8'h00, 8'h34, 8'hCB, 8'h99, 2);
        // Inputs changing mid-frame must not affect the shifted data.
        cmd = 8'hFF; addr = 8'h00; wdata = 8'h00;
        wait_done(base + 1, "write");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read();
        int base = frames_done;
        start_frame(8'hA5, 8'h12, 8'hED, 8'h3C, 1);
        wait_done(base + 1, "read");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read_ones();
        int base = frames_done;
        start_frame(8'hFF, 8'h67, 8'h00, 8'hFF, 1);
        wait_done(base + 1, "read_ones");
        start_frame(8'h00, 8'h55, 8'hAA, 8'h00, 1);
        wait_done(base + 2, "write_after_read");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_en_ignored();
        int base_s = frames_started;
        int base_d = frames_done;
        start_frame(8'h5A, 8'hC3, 8'h0F, 8'h00, 1);
        repeat (10) @(negedge clk);
        en = 1'b1; @(negedge clk); en = 1'b0;
        wait_done(base_d + 1, "en_ignored");
        repeat (60) @(negedge clk);
        checks++;
        if (frames_started !== base_s + 1) begin
            bad++; $display("FAIL en_ignored_frames: got %0d required %0d", frames_started - base_s, 1);
        end
    endtask

    task automatic test_back_to_back();
        int base_s = frames_started;
        int base_d = frames_done;
        int n = 0;
        logic [23:0] f;
        cmd = 8'h11; addr = 8'h22; wdata = 8'h33;
        f = {cmd, addr, wdata};
        for (int k = 0; k < 2; k++) begin
            for (int i = 23; i >= 0; i--) exp_mosi.push_back(f[i]);
            exp_dout.push_back(dout_model);
        end
        @(negedge clk);
        en = 1'b1;
        while (frames_started < base_s + 2 && n < 1000) begin @(negedge clk); n++; end
        en = 1'b0;
        wait_done(base_d + 2, "back_to_back");
        checks++;
        if (last_gap !== 2) begin
            bad++; $display("FAIL b2b_gap: got %0d cycles required 2", last_gap);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_slow();
        int n = 0;
        cmd = 8'h00; addr = 8'h34; wdata = 8'hCB;
        @(negedge clk);
        en3 = 1'b1;
        while (gap3_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
        en3 = 1'b0;
        n = 0;
        while (low3_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (low3_q.size() < 2 || gap3_q.size() < 2) begin
            bad++; $display("FAIL slow_timeout: got %0d frames required 2", low3_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (low3_q[k] !== 144) begin
                    bad++; $display("FAIL slow_cs_window: got %0d required 144", low3_q[k]);
                end
                checks++;
                if (pulses3_q[k] !== 24) begin
                    bad++; $display("FAIL slow_pulses: got %0d required 24", pulses3_q[k]);
                end
            end
            checks++;
            if (gap3_q[1] !== 2) begin
                bad++; $display("FAIL slow_gap: got %0d required 2", gap3_q[1]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        start_frame(8'h80, 8'h01, 8'h00, 8'hA7, 1);
        repeat (20) @(negedge clk);
        checks++;
        if (cs !== 1'b0) begin bad++; $display("FAIL abort_precond_cs: got %b required 0", cs); end
        aborting = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (cs !== 1'b1) begin bad++; $display("FAIL abort_cs: got %b required 1", cs); end
        checks++; if (sck !== 1'b0) begin bad++; $display("FAIL abort_sck: got %b required 0", sck); end
        #49;
        checks++; if (dout !== 8'h00) begin bad++; $display("FAIL abort_dout: got %h required 00", dout); end
        exp_mosi.delete();
        exp_dout.delete();
        dout_model = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        aborting = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (cs !== 1'b1 || mosi !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got cs=%b mosi=%b required cs=1 mosi=0", cs, mosi);
        end
        // Recovery: a normal write after the abort.
        start_frame(8'h00, 8'h34, 8'hCB, 8'h00, 1);
        wait_done(frames_done + 1, "after_abort");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_ones();
        test_en_ignored();
        test_reset_abort();
        test_back_to_back();
        test_slow();
        checks++;
        if (exp_mosi.size() != 0 || exp_dout.size() != 0) begin
            bad++; $display("FAIL leftover_expectations: got %0d/%0d required 0/0", exp_mosi.size(), exp_dout.size());
        end
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-transaction SPI master. Mode 0 (CPOL=0, CPHA=0), MSB first, one active-low chip select.
- On a start request it sends an 8-bit command and an 8-bit address.
- It then either transmits an 8-bit data byte (write) or receives one (read).
- It sits between a local register/bus controller (the ext_* side) and an external SPI slave device.

Parameters:
- SCK_HALF, default 1: clk cycles per sck half-period (sck frequency = clk / (2*SCK_HALF)). Must be ≥1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start request. Level-sampled only in IDLE; may be a 1–2 cycle pulse.
- cs  output  1  chip select, active low; registered.
- sck  output  1  serial clock, idles low; registered.
- ext_command_in  input  8  command byte. Bit 7 = 1 selects read, 0 selects write.
- ext_address_in  input  8  address byte.
- ext_data_in  input  8  write data byte.
- mosi  output  1  serial data out; registered.
- miso  input  1  serial data in.
- ext_data_out  output  8  last byte received by a read; registered and held.

Behaviour:
- Reset (async, while rst=1): state IDLE, cs=1, sck=0, mosi=0, ext_data_out=8'h00, all counters and shift registers cleared. Reset mid-transaction aborts immediately; no partial ext_data_out update.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - cs=1, sck=0, mosi=0.
  - On a clk edge with en=1: latch frame = {ext_command_in, ext_address_in, ext_data_in} (24 bits) and latch rd = ext_command_in[7].
  - On that same edge: cs goes 0, mosi drives frame[23], bit counter=0, go to SHIFT.
- SHIFT:
  - The half-period counter counts SCK_HALF clk cycles, then toggles sck.
  - Rising sck (0→1): if rd and bit index ≥16, shift the registered miso value into rx register, MSB first.
  - Falling sck (1→0): if bit index = 23, go to DONE. Otherwise increment index and drive the next frame bit on mosi.
  - During the data phase of a read (index 16..23), mosi = 0.
- Timing with cs falling at edge T0:
  - sck rises at T0+(2k+1)*SCK_HALF and falls at T0+(2k+2)*SCK_HALF, for k=0..23.
  - cs low for exactly 48*SCK_HALF cycles; 24 sck pulses.
- DONE (entered on the 24th falling sck):
  - Same edge: cs=1, sck=0, mosi=0.
  - If rd: ext_data_out <= rx byte on that edge. Write transactions leave ext_data_out unchanged.
  - Stays one cycle, then IDLE.
- en is ignored while in SHIFT or DONE.
- If en is still high on return to IDLE, a new transaction starts using the current inputs.
- Inputs are only sampled at start; changes mid-transaction have no effect.
- miso is sampled without a synchronizer. The slave must drive it stable around sck rising edges.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - FRAME_BITS=24, DATA_START_BIT=16, CMD_READ_BIT=7.
- One natural sub-module: spi_sck_gen. It holds the half-period counter and emits sck plus single-cycle rise/fall strobes, gated by an enable from the FSM.
- The FSM and shift registers stay in spi_master.

Test Plan:
- Reset: hold rst 50 ns mid-run → cs=1, sck=0, mosi=0, ext_data_out=00. Asserting rst during SHIFT aborts: cs=1 immediately and the FSM returns to IDLE.
- Write: cmd=00, addr=34, data=CB, en pulse 1–2 cycles → mosi bits on sck rises = 0x0034CB MSB first; 24 sck pulses; cs low 48*SCK_HALF cycles; ext_data_out unchanged.
- Read: cmd=A5, addr=12, data=ED, slave model shifts out 0x3C in bits 16–23 → mosi = A5,12 then 0s; ext_data_out=3C on the cycle cs rises.
- Read all-ones: cmd=FF, addr=67, miso held 1 → ext_data_out=FF. A following write (cmd=00) leaves FF.
- en pulsed again mid-transaction → ignored: exactly 24 sck pulses, single cs low window.
- Back-to-back: en held high → second transaction starts 1 cycle after DONE with cs high for at least 2 cycles between frames. Repeat with SCK_HALF=3 and check the 144-cycle cs window.
